// File: rtl/hub_message_router_if.sv
// rtl/hub_message_router_if.sv - upstream FWFT drain handshake and per-port output bundle
interface hub_message_router_if #(
   parameter int HUB_FIFO_WIDTH = 32,
   parameter int NUM_PORTS      = 4
);
   logic [HUB_FIFO_WIDTH-1:0]           wide_fifo_data;
   logic                                wide_fifo_valid;
   logic                                wide_fifo_ready;
   logic [NUM_PORTS*HUB_FIFO_WIDTH-1:0] out_data;
   logic [NUM_PORTS-1:0]                out_valid;
   logic [NUM_PORTS-1:0]                out_ready;

   modport master (
      input  wide_fifo_data, wide_fifo_valid, out_ready,
      output wide_fifo_ready, out_data, out_valid
   );

   modport slave (
      output wide_fifo_data, wide_fifo_valid, out_ready,
      input  wide_fifo_ready, out_data, out_valid
   );
endinterface

// File: rtl/hub_message_router.sv
// rtl/hub_message_router.sv - routes hub messages by destination field into per-port 2-entry FIFOs
module hub_message_router #(
   parameter int HUB_FIFO_WIDTH = 32,
   parameter int NUM_PORTS      = 4,
   parameter int DEST_WIDTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   hub_message_router_if.master hub,
   output logic [15:0]          drop_count
);
   localparam int W = HUB_FIFO_WIDTH;
   localparam logic [DEST_WIDTH-1:0] NP_D = DEST_WIDTH'(NUM_PORTS);

   logic [W-1:0]           mem_q   [NUM_PORTS][2];
   logic [W-1:0]           mem_d   [NUM_PORTS][2];
   logic [1:0]             count_q [NUM_PORTS];
   logic [1:0]             count_d [NUM_PORTS];
   logic [NUM_PORTS-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [NUM_PORTS-1:0]   space, push, pop;
   logic [15:0]            drop_count_q, drop_count_d;
   logic [DEST_WIDTH-1:0]  dest;
   logic                   is_uni, is_bcast, uni_space, accept, ready;

   always_comb begin
      dest      = hub.wide_fifo_data[W-1 -: DEST_WIDTH];
      is_uni    = dest < NP_D;
      is_bcast  = &dest;
      uni_space = 1'b0;
      // Space comes from registered counts only, keeping out_ready off the wide_fifo_ready path.
      for (int i = 0; i < NUM_PORTS; i++) begin
         space[i] = count_q[i] != 2'd2;
         if (dest == DEST_WIDTH'(i)) uni_space = space[i];
      end
      accept = is_uni ? uni_space : (is_bcast ? &space : 1'b1);
      ready  = !reset && hub.wide_fifo_valid && accept;

      for (int i = 0; i < NUM_PORTS; i++) begin
         push[i]     = ready && (is_bcast || (is_uni && dest == DEST_WIDTH'(i)));
         pop[i]      = (count_q[i] != 2'd0) && hub.out_ready[i];
         mem_d[i]    = mem_q[i];
         if (push[i]) mem_d[i][wr_ptr_q[i]] = hub.wide_fifo_data;
         wr_ptr_d[i] = wr_ptr_q[i] ^ push[i];
         rd_ptr_d[i] = rd_ptr_q[i] ^ pop[i];
         count_d[i]  = count_q[i] + 2'(push[i]) - 2'(pop[i]);
      end

      drop_count_d = drop_count_q;
      if (ready && !is_uni && !is_bcast && drop_count_q != 16'hFFFF)
         drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            count_q[i]  <= 2'd0;
            mem_q[i][0] <= '0;
            mem_q[i][1] <= '0;
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         drop_count_q <= 16'd0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            count_q[i] <= count_d[i];
            mem_q[i]   <= mem_d[i];
         end
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      hub.out_data  = '0;
      hub.out_valid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         hub.out_valid[i]        = count_q[i] != 2'd0;
         hub.out_data[i*W +: W]  = mem_q[i][rd_ptr_q[i]];
      end
   end

   assign hub.wide_fifo_ready = ready;
   assign drop_count          = drop_count_q;
endmodule

// File: tb/tb_hub_message_router.sv
// tb/tb_hub_message_router.sv - vector table plus scoreboard model for hub_message_router
module tb_hub_message_router;
   localparam int W  = 32;
   localparam int NP = 4;
   localparam int DW = 4;

   typedef struct {
      logic [W-1:0]  data;
      logic          valid;
      logic [NP-1:0] ordy;
      logic          exp_ready;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] drop_count;
   int          vec_count  = 0;
   int          miscompares = 0;
   logic        mon_en = 1'b0;
   logic [W-1:0] exp_q [NP][$];
   logic [15:0]  m_drop = 16'd0;
   vec_t         vecs[$];

   always #5 clk = ~clk;

   hub_message_router_if #(.HUB_FIFO_WIDTH(W), .NUM_PORTS(NP)) hub_bus ();

   hub_message_router #(.HUB_FIFO_WIDTH(W), .NUM_PORTS(NP), .DEST_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .hub        (hub_bus.master),
      .drop_count (drop_count)
   );

   task automatic chk(input string nm, input logic [NP*W-1:0] got, input logic [NP*W-1:0] want);
      vec_count++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s t=%0t got %0h want %0h", nm, $time, got, want);
      end
   endtask

   task automatic drive(input logic [W-1:0] d, input logic v, input logic [NP-1:0] r);
      @(posedge clk);
      #1;
      hub_bus.wide_fifo_data  = d;
      hub_bus.wide_fifo_valid = v;
      hub_bus.out_ready       = r;
   endtask

   // Scoreboard: predicts ready from queue occupancy, checks outputs, then advances the model.
   always @(negedge clk) begin
      logic [DW-1:0] d;
      logic          acc, want_rdy;
      if (mon_en) begin
         d   = hub_bus.wide_fifo_data[W-1 -: DW];
         acc = 1'b1;
         if (d < NP) acc = exp_q[d].size() < 2;
         else if (d == 4'hF) for (int p = 0; p < NP; p++) if (exp_q[p].size() >= 2) acc = 1'b0;
         want_rdy = !reset && hub_bus.wide_fifo_valid && acc;
         chk("sb_ready", {127'd0, hub_bus.wide_fifo_ready}, {127'd0, want_rdy});
         chk("sb_drop", {112'd0, drop_count}, {112'd0, m_drop});
         for (int p = 0; p < NP; p++) begin
            chk("sb_valid", {127'd0, hub_bus.out_valid[p]}, {127'd0, exp_q[p].size() != 0});
            if (exp_q[p].size() != 0)
               chk("sb_data", {96'd0, hub_bus.out_data[p*W +: W]}, {96'd0, exp_q[p][0]});
         end
         if (reset) begin
            for (int p = 0; p < NP; p++) exp_q[p].delete();
            m_drop = 16'd0;
         end else begin
            for (int p = 0; p < NP; p++)
               if (exp_q[p].size() != 0 && hub_bus.out_ready[p]) void'(exp_q[p].pop_front());
            if (want_rdy) begin
               if (d < NP) exp_q[d].push_back(hub_bus.wide_fifo_data);
               else if (d == 4'hF) for (int p = 0; p < NP; p++) exp_q[p].push_back(hub_bus.wide_fifo_data);
               else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
         end
      end
   end

   initial begin
      vecs.push_back('{32'h1234_5678, 1'b1, 4'b1111, 1'b1});
      vecs.push_back('{32'h3ABC_DEF0, 1'b1, 4'b1111, 1'b1});
      vecs.push_back('{32'h0000_0000, 1'b0, 4'b1111, 1'b0});
      vecs.push_back('{32'h0000_0001, 1'b1, 4'b1110, 1'b1});
      vecs.push_back('{32'h0000_0002, 1'b1, 4'b1110, 1'b1});
      vecs.push_back('{32'h0000_0003, 1'b1, 4'b1110, 1'b0});
      vecs.push_back('{32'h0000_0003, 1'b1, 4'b1110, 1'b0});
      vecs.push_back('{32'h0000_0003, 1'b1, 4'b1111, 1'b0});
      vecs.push_back('{32'h0000_0003, 1'b1, 4'b1111, 1'b1});
      vecs.push_back('{32'h0000_0000, 1'b0, 4'b1111, 1'b0});
      for (int k = 5; k <= 14; k++) vecs.push_back('{{4'(k), 28'h0}, 1'b1, 4'b1111, 1'b1});
      vecs.push_back('{32'h0000_0000, 1'b0, 4'b1111, 1'b0});

      reset = 1'b1;
      hub_bus.wide_fifo_data  = 32'h1000_0000;
      hub_bus.wide_fifo_valid = 1'b1;
      hub_bus.out_ready       = 4'b1111;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_ready", {127'd0, hub_bus.wide_fifo_ready}, 128'd0);
      chk("rst_valid", {124'd0, hub_bus.out_valid}, 128'd0);
      chk("rst_data", hub_bus.out_data, 128'd0);
      chk("rst_drop", {112'd0, drop_count}, 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      hub_bus.wide_fifo_valid = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].data, vecs[i].valid, vecs[i].ordy);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), {127'd0, hub_bus.wide_fifo_ready}, {127'd0, vecs[i].exp_ready});
      end
      chk("drop_ten", {112'd0, drop_count}, 128'd10);

      // Broadcast blocked behind a full port 2 until it drains one entry.
      drive(32'h2000_0011, 1'b1, 4'b1011);
      drive(32'h2000_0022, 1'b1, 4'b1011);
      for (int k = 0; k < 3; k++) begin
         drive(32'hF000_00AA, 1'b1, 4'b1011);
         @(negedge clk);
         chk("bcast_wait", {127'd0, hub_bus.wide_fifo_ready}, 128'd0);
      end
      drive(32'hF000_00AA, 1'b1, 4'b1111);
      @(negedge clk);
      chk("bcast_pop_cycle", {127'd0, hub_bus.wide_fifo_ready}, 128'd0);
      drive(32'hF000_00AA, 1'b1, 4'b1111);
      @(negedge clk);
      chk("bcast_accept", {127'd0, hub_bus.wide_fifo_ready}, 128'd1);
      drive(32'h0, 1'b0, 4'b1111);
      @(negedge clk);
      chk("bcast_valid", {124'd0, hub_bus.out_valid}, 128'hF);
      chk("bcast_data", hub_bus.out_data, {4{32'hF000_00AA}});

      // Streaming to port 0 at one word per cycle.
      for (int k = 0; k < 16; k++) begin
         drive(32'h0000_0100 + k, 1'b1, 4'b1111);
         @(negedge clk);
         chk("stream_ready", {127'd0, hub_bus.wide_fifo_ready}, 128'd1);
         if (k > 0) chk("stream_data", {96'd0, hub_bus.out_data[31:0]}, {96'd0, 32'h0000_0100 + k - 1});
      end
      drive(32'h0, 1'b0, 4'b1111);

      // Saturation of drop_count.
      drive(32'h0, 1'b0, 4'b1111);
      force dut.drop_count_q = 16'hFFFD;
      m_drop = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut.drop_count_q;
      for (int k = 0; k < 4; k++) drive(32'h7000_0000, 1'b1, 4'b1111);
      drive(32'h0, 1'b0, 4'b1111);
      @(negedge clk);
      chk("drop_sat", {112'd0, drop_count}, 128'hFFFF);

      // Reset while ports 0 and 1 hold two entries each.
      drive(32'h0000_00A1, 1'b1, 4'b1100);
      drive(32'h0000_00A2, 1'b1, 4'b1100);
      drive(32'h1000_00B1, 1'b1, 4'b1100);
      drive(32'h1000_00B2, 1'b1, 4'b1100);
      drive(32'h2000_00C1, 1'b0, 4'b1100);
      @(negedge clk);
      chk("pre_rst_valid", {124'd0, hub_bus.out_valid}, 128'h3);
      drive(32'h2000_00C1, 1'b1, 4'b1100);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {127'd0, hub_bus.wide_fifo_ready}, 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", {124'd0, hub_bus.out_valid}, 128'd0);
      chk("post_rst_data", hub_bus.out_data, 128'd0);
      chk("post_rst_drop", {112'd0, drop_count}, 128'd0);
      chk("post_rst_ready", {127'd0, hub_bus.wide_fifo_ready}, 128'd1);
      drive(32'h0, 1'b0, 4'b1111);
      @(negedge clk);
      chk("post_rst_route", {124'd0, hub_bus.out_valid}, 128'h4);
      chk("post_rst_rdata", {96'd0, hub_bus.out_data[2*W +: W]}, {96'd0, 32'h2000_00C1});

      for (int k = 0; k < 4; k++) drive(32'h0, 1'b0, 4'b1111);
      @(negedge clk);
      chk("drained", {124'd0, hub_bus.out_valid}, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end
endmodule
